// File: rtl/ps2_cmd_ctrlr.sv
// ps2_cmd_ctrlr: PS/2 host-to-device command sequencer.
// Sends a one- or two-byte command over the shared PS2_CLK/PS2_DAT lines.
// Each byte goes out as a host-transmit frame. The keyboard's 0xFA reply,
// seen through the scan-code receiver, completes the byte. 0xFE, any other
// reply, a missing line ack or a timeout causes a retry, up to MAX_RETRY
// attempts per byte.
module ps2_cmd_ctrlr #(
    parameter int INHIBIT_CYC = 5000,
    parameter int RTS_TO_CYC  = 750000,
    parameter int ACK_TO_CYC  = 1000000,
    parameter int MAX_RETRY   = 3,
    parameter int FILT_LEN    = 8
) (
    input  logic       CLOCK_50,
    input  logic       clr_n,
    // Command handshake: one command transfers on a cycle where both
    // cmd_valid and cmd_ready are high. cmd_byte, cmd_has_arg and cmd_arg are
    // sampled only on that cycle. cmd_valid while cmd_ready is low is dropped.
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       done,
    output logic       err,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_busy,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_RTS      = 3'd2,
        S_SHIFT    = 3'd3,
        S_LINE_ACK = 3'd4,
        S_WAIT_RSP = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    // Input synchronizers and glitch filters
    logic          clk_m_q, clk_s_q, dat_m_q, dat_s_q;
    logic          clk_f_q, clk_f_d, dat_f_q, dat_f_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
    logic          clk_fall;

    // Sequencer state
    state_t      state_q;
    logic [31:0] tmr_q;
    logic [3:0]  fall_cnt_q;
    logic [7:0]  retry_q;
    logic [7:0]  cur_q;
    logic [7:0]  arg_q;
    logic        has_arg_q;
    logic        sending_arg_q;
    logic        ack_seen_q;
    logic        cmd_ready_q, done_q, err_q, clk_oe_q, dat_oe_q, busy_q;
    logic        fail_now;
    logic        last_try;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge CLOCK_50) begin
        if (!clr_n) begin
            clk_m_q <= 1'b1;
            clk_s_q <= 1'b1;
            dat_m_q <= 1'b1;
            dat_s_q <= 1'b1;
        end else begin
            clk_m_q <= PS2_CLK;
            clk_s_q <= clk_m_q;
            dat_m_q <= PS2_DAT;
            dat_s_q <= dat_m_q;
        end
    end

    // Filter: a new level is accepted after FILT_LEN consecutive differing samples.
    always_comb begin
        clk_f_d   = clk_f_q;
        clk_cnt_d = clk_cnt_q;
        dat_f_d   = dat_f_q;
        dat_cnt_d = dat_cnt_q;
        if (clk_s_q == clk_f_q) begin
            clk_cnt_d = '0;
        end else if (clk_cnt_q == CW'(FILT_LEN - 1)) begin
            clk_f_d   = clk_s_q;
            clk_cnt_d = '0;
        end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
        end
        if (dat_s_q == dat_f_q) begin
            dat_cnt_d = '0;
        end else if (dat_cnt_q == CW'(FILT_LEN - 1)) begin
            dat_f_d   = dat_s_q;
            dat_cnt_d = '0;
        end else begin
            dat_cnt_d = dat_cnt_q + 1'b1;
        end
    end

    // Filter state registers, preset to the idle-high level.
    always_ff @(posedge CLOCK_50) begin
        if (!clr_n) begin
            clk_f_q   <= 1'b1;
            dat_f_q   <= 1'b1;
            clk_cnt_q <= '0;
            dat_cnt_q <= '0;
        end else begin
            clk_f_q   <= clk_f_d;
            dat_f_q   <= dat_f_d;
            clk_cnt_q <= clk_cnt_d;
            dat_cnt_q <= dat_cnt_d;
        end
    end

    // A fall is the cycle in which the filtered clock is about to go 1 -> 0.
    assign clk_fall = clk_f_q & ~clk_f_d;

    // The attempt in progress is the last one allowed for this byte.
    assign last_try = (32'(retry_q) + 32'd1) >= 32'(MAX_RETRY);

    // Conditions that abandon the current attempt.
    always_comb begin
        fail_now = 1'b0;
        case (state_q)
            S_RTS:      fail_now = !clk_fall && (tmr_q == 32'(RTS_TO_CYC - 1));
            S_LINE_ACK: fail_now = !ack_seen_q && clk_fall && dat_f_q;
            S_WAIT_RSP: fail_now = rx_valid ? (rx_byte != 8'hFA)
                                            : (tmr_q == 32'(ACK_TO_CYC - 1));
            default:    fail_now = 1'b0;
        endcase
    end

    // Command sequencer: transmit frames, check line ack and response, retry.
    always_ff @(posedge CLOCK_50) begin
        if (!clr_n) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            fall_cnt_q    <= '0;
            retry_q       <= '0;
            cur_q         <= '0;
            arg_q         <= '0;
            has_arg_q     <= 1'b0;
            sending_arg_q <= 1'b0;
            ack_seen_q    <= 1'b0;
            cmd_ready_q   <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            clk_oe_q      <= 1'b0;
            dat_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    clk_oe_q    <= 1'b0;
                    dat_oe_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    if (cmd_valid && cmd_ready_q) begin
                        cur_q         <= cmd_byte;
                        arg_q         <= cmd_arg;
                        has_arg_q     <= cmd_has_arg;
                        sending_arg_q <= 1'b0;
                        retry_q       <= '0;
                        cmd_ready_q   <= 1'b0;
                        clk_oe_q      <= 1'b1;
                        busy_q        <= 1'b1;
                        tmr_q         <= '0;
                        fall_cnt_q    <= '0;
                        state_q       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (tmr_q == 32'(INHIBIT_CYC - 1)) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b1;
                        tmr_q    <= '0;
                        state_q  <= S_RTS;
                    end else begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                S_RTS: begin
                    if (clk_fall) begin
                        fall_cnt_q <= 4'd1;
                        dat_oe_q   <= ~cur_q[0];
                        state_q    <= S_SHIFT;
                    end else begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                S_SHIFT: begin
                    // fall_cnt_q holds the index of the previous fall.
                    if (clk_fall) begin
                        fall_cnt_q <= fall_cnt_q + 4'd1;
                        if (fall_cnt_q == 4'd9) begin
                            dat_oe_q   <= 1'b0;
                            ack_seen_q <= 1'b0;
                            state_q    <= S_LINE_ACK;
                        end else if (fall_cnt_q == 4'd8) begin
                            // Odd parity bit is ~^byte; drive low when it is 0.
                            dat_oe_q <= ^cur_q;
                        end else begin
                            dat_oe_q <= ~cur_q[fall_cnt_q[2:0]];
                        end
                    end
                end
                S_LINE_ACK: begin
                    if (!ack_seen_q) begin
                        if (clk_fall) begin
                            fall_cnt_q <= fall_cnt_q + 4'd1;
                            ack_seen_q <= 1'b1;
                        end
                    end else if (clk_f_q && dat_f_q) begin
                        busy_q  <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (rx_valid && rx_byte == 8'hFA) begin
                        if (!sending_arg_q && has_arg_q) begin
                            cur_q         <= arg_q;
                            sending_arg_q <= 1'b1;
                            retry_q       <= '0;
                            clk_oe_q      <= 1'b1;
                            dat_oe_q      <= 1'b0;
                            busy_q        <= 1'b1;
                            tmr_q         <= '0;
                            fall_cnt_q    <= '0;
                            state_q       <= S_INHIBIT;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (!rx_valid) begin
                        tmr_q <= tmr_q + 32'd1;
                    end
                end
                S_FAIL: begin
                    clk_oe_q   <= 1'b1;
                    dat_oe_q   <= 1'b0;
                    busy_q     <= 1'b1;
                    tmr_q      <= '0;
                    fall_cnt_q <= '0;
                    state_q    <= S_INHIBIT;
                end
                default: state_q <= S_IDLE;
            endcase

            // A failed attempt counts immediately; the final failure reports
            // err in the next cycle rather than passing through S_FAIL.
            if (fail_now) begin
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                tmr_q    <= '0;
                retry_q  <= retry_q + 8'd1;
                if (last_try) begin
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end else begin
                    state_q <= S_FAIL;
                end
            end
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_busy    = busy_q;
    assign dbg_state  = state_q;

endmodule
